// File: rtl/axi_read_arbiter.sv
// Two-master, single-outstanding AXI read arbiter onto one slave read port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise master 0 always has priority.
module axi_read_arbiter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [63:0] m_araddr,
   input  logic [5:0]  m_arprot,
   input  logic [1:0]  m_arvalid,
   output logic [1:0]  m_arready,
   output logic [63:0] m_rdata,
   output logic [3:0]  m_rresp,
   output logic [1:0]  m_rvalid,
   input  logic [1:0]  m_rready,
   output logic [31:0] s_araddr,
   output logic [2:0]  s_arprot,
   output logic        s_arvalid,
   input  logic        s_arready,
   input  logic [31:0] s_rdata,
   input  logic [1:0]  s_rresp,
   input  logic        s_rvalid,
   output logic        s_rready
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t      state_q, state_d;
   logic        g_q, g_d;
   logic        prio;
   logic        win;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  prot_q, prot_d;
   logic [1:0]  arready_c;

`ifdef ARB_ROUND_ROBIN_EN
   logic p_q, p_d;

   assign prio = p_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) p_q <= 1'b0;
      else          p_q <= p_d;
   end
`else
   assign prio = 1'b0;
`endif

   // A lone requester wins outright; under contention the priority pointer decides.
   assign win = (m_arvalid == 2'b11) ? prio : m_arvalid[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         g_q     <= 1'b0;
         addr_q  <= '0;
         prot_q  <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         addr_q  <= addr_d;
         prot_q  <= prot_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      addr_d    = addr_q;
      prot_d    = prot_q;
`ifdef ARB_ROUND_ROBIN_EN
      p_d       = p_q;
`endif
      arready_c = '0;
      m_rvalid  = '0;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|m_arvalid) begin
               arready_c[win] = 1'b1;
               g_d     = win;
               addr_d  = win ? m_araddr[63:32] : m_araddr[31:0];
               prot_d  = win ? m_arprot[5:3]   : m_arprot[2:0];
               state_d = ADDR;
            end
         end
         ADDR: begin
            s_arvalid = 1'b1;
            if (s_arready) state_d = DATA;
         end
         DATA: begin
            m_rvalid[g_q] = s_rvalid;
            s_rready      = m_rready[g_q];
            if (s_rvalid && m_rready[g_q]) begin
               state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
               p_d     = ~g_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The accept strobe is combinational from m_arvalid, so reset must mask it directly.
   assign m_arready = arready_c & {2{reset_n}};
   assign s_araddr  = addr_q;
   assign s_arprot  = prot_q;
   assign m_rdata   = {2{s_rdata}};
   assign m_rresp   = {2{s_rresp}};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_axi_read_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   localparam logic [31:0] A0   = 32'h0000_1000;
   localparam logic [31:0] A1   = 32'h0000_2000;
   localparam logic [31:0] A_RR = RR ? A1 : A0;
   localparam logic [1:0]  G_RR = RR ? 2'b10 : 2'b01;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] m_araddr;
   logic [5:0]  m_arprot;
   logic [1:0]  m_arvalid;
   logic [1:0]  m_arready;
   logic [63:0] m_rdata;
   logic [3:0]  m_rresp;
   logic [1:0]  m_rvalid;
   logic [1:0]  m_rready;
   logic [31:0] s_araddr;
   logic [2:0]  s_arprot;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;

   int n_vec = 0;
   int n_err = 0;

   axi_read_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .m_araddr  (m_araddr),
      .m_arprot  (m_arprot),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .s_araddr  (s_araddr),
      .s_arprot  (s_arprot),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  arv;
      logic        sar;
      logic        srv;
      logic [1:0]  rrdy;
      logic [1:0]  rresp;
      logic [1:0]  e_arready;
      logic        e_sarv;
      logic [31:0] e_saddr;
      logic [1:0]  e_rvalid;
      logic        e_srr;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] arv, input logic sar, input logic srv,
                        input logic [1:0] rrdy, input logic [1:0] resp);
      m_arvalid = arv;
      s_arready = sar;
      s_rvalid  = srv;
      m_rready  = rrdy;
      s_rresp   = resp;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] prot_of(input logic [31:0] a);
      if (a == A0) return 3'b001;
      if (a == A1) return 3'b110;
      return 3'b000;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[16];
      // reference model state for the random phase
      bit          busy, sent, owner, mp, w;
      logic [31:0] maddr;
      logic [2:0]  mprot;
      bit          pend[2];
      logic [31:0] req_addr[2];
      logic [2:0]  req_prot[2];
      logic [1:0]  e_ar, e_rv;
      logic        e_sv, e_sr;

      //             arv   sar   srv   rrdy   rresp  e_ar   e_sv  e_saddr e_rv   e_sr
      tbl[0]  = '{2'b01, 1'b1, 1'b1, 2'b11, 2'b00, 2'b01, 1'b0, 32'h0,  2'b00, 1'b0};
      tbl[1]  = '{2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1, A0,     2'b00, 1'b0};
      tbl[2]  = '{2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, A0,     2'b01, 1'b1};
      tbl[3]  = '{2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, A0,     2'b00, 1'b0};
      tbl[4]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, A1,     2'b00, 1'b0};
      tbl[5]  = '{2'b00, 1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 1'b0, A1,     2'b10, 1'b0};
      tbl[6]  = '{2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 1'b0, A1,     2'b10, 1'b1};
      tbl[7]  = '{2'b11, 1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 1'b0, A1,     2'b00, 1'b0};
      tbl[8]  = '{2'b11, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, A0,     2'b00, 1'b0};
      tbl[9]  = '{2'b11, 1'b0, 1'b1, 2'b11, 2'b01, 2'b00, 1'b0, A0,     2'b01, 1'b1};
      tbl[10] = '{2'b11, 1'b0, 1'b0, 2'b11, 2'b00, G_RR,  1'b0, A0,     2'b00, 1'b0};
      tbl[11] = '{2'b11, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, A_RR,   2'b00, 1'b0};
      tbl[12] = '{2'b11, 1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, A_RR,   G_RR,  1'b1};
      tbl[13] = '{2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 2'b01, 1'b0, A_RR,   2'b00, 1'b0};
      tbl[14] = '{2'b00, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, A0,     2'b00, 1'b0};
      tbl[15] = '{2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, A0,     2'b01, 1'b1};

      reset_n  = 1'b0;
      m_araddr = {A1, A0};
      m_arprot = {3'b110, 3'b001};
      s_rdata  = 32'hDEAD_BEEF;
      drive(2'b11, 1'b1, 1'b1, 2'b11, 2'b00);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("reset outputs", {m_arready, s_arvalid, s_araddr, s_arprot, m_rvalid, s_rready}, '0);
      next_cycle();
      drive(2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
      reset_n = 1'b1;
      next_cycle();

      // directed vector table
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].arv, tbl[i].sar, tbl[i].srv, tbl[i].rrdy, tbl[i].rresp);
         @(negedge clk);
         chk($sformatf("tbl[%0d] arready", i), m_arready, tbl[i].e_arready);
         chk($sformatf("tbl[%0d] s_ar", i), {s_arvalid, s_araddr, s_arprot},
             {tbl[i].e_sarv, tbl[i].e_saddr, prot_of(tbl[i].e_saddr)});
         chk($sformatf("tbl[%0d] r", i), {m_rvalid, s_rready, m_rresp, m_rdata},
             {tbl[i].e_rvalid, tbl[i].e_srr, {tbl[i].rresp, tbl[i].rresp}, 64'hDEADBEEF_DEADBEEF});
         next_cycle();
      end

      // backpressure: m1 alone, address stalled 5 cycles, then read data stalled 3 cycles
      drive(2'b10, 1'b0, 1'b0, 2'b00, 2'b00);
      @(negedge clk);
      chk("bp accept", m_arready, 2'b10);
      next_cycle();
      drive(2'b00, 1'b0, 1'b1, 2'b11, 2'b00);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp ar stall %0d", k), {s_arvalid, s_araddr, s_arprot, m_rvalid, s_rready},
             {1'b1, A1, 3'b110, 2'b00, 1'b0});
         next_cycle();
      end
      drive(2'b00, 1'b1, 1'b0, 2'b00, 2'b00);
      @(negedge clk);
      chk("bp ar release", s_arvalid, 1'b1);
      next_cycle();
      drive(2'b00, 1'b0, 1'b1, 2'b01, 2'b00);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp r stall %0d", k), {s_arvalid, m_rvalid, s_rready}, {1'b0, 2'b10, 1'b0});
         next_cycle();
      end
      drive(2'b00, 1'b0, 1'b1, 2'b10, 2'b00);
      @(negedge clk);
      chk("bp r handshake", {m_rvalid, s_rready}, {2'b10, 1'b1});
      next_cycle();
      drive(2'b00, 1'b1, 1'b1, 2'b11, 2'b00);
      @(negedge clk);
      chk("bp back to idle", {m_arready, s_arvalid, m_rvalid, s_rready}, '0);
      next_cycle();

      // reset in DATA with priority pointing at m1 (round-robin); m0 must win after release
      drive(2'b01, 1'b1, 1'b0, 2'b11, 2'b00);
      next_cycle();
      drive(2'b00, 1'b1, 1'b0, 2'b11, 2'b00);
      next_cycle();
      drive(2'b00, 1'b0, 1'b1, 2'b11, 2'b00);
      next_cycle();
      drive(2'b11, 1'b1, 1'b0, 2'b11, 2'b00);
      @(negedge clk);
      chk("rst pre grant", m_arready, G_RR);
      next_cycle();
      next_cycle();
      drive(2'b11, 1'b1, 1'b1, 2'b11, 2'b00);
      @(negedge clk);
      chk("rst in data", {m_rvalid, s_rready}, {G_RR, 1'b1});
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst async clear", {m_arready, s_arvalid, s_araddr, s_arprot, m_rvalid, s_rready}, '0);
      next_cycle();
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst first grant m0", {m_arready, s_arvalid}, {2'b01, 1'b0});
      next_cycle();

      // randomized traffic against a transaction-level model
      reset_n = 1'b0;
      drive(2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
      next_cycle();
      reset_n = 1'b1;
      busy = 0; sent = 0; owner = 0; mp = 0; w = 0;
      maddr = '0; mprot = '0;
      pend[0] = 0; pend[1] = 0;
      req_addr[0] = '0; req_addr[1] = '0;
      req_prot[0] = '0; req_prot[1] = '0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i]     = 1;
               req_addr[i] = $urandom;
               req_prot[i] = 3'($urandom);
            end
         end
         m_arvalid = {pend[1], pend[0]};
         m_araddr  = {req_addr[1], req_addr[0]};
         m_arprot  = {req_prot[1], req_prot[0]};
         s_arready = 1'($urandom);
         s_rvalid  = 1'($urandom);
         m_rready  = 2'($urandom);
         s_rdata   = $urandom;
         s_rresp   = 2'($urandom);
         @(negedge clk);

         e_ar = '0; e_sv = 1'b0; e_rv = '0; e_sr = 1'b0;
         w = (m_arvalid == 2'b11) ? mp : (m_arvalid == 2'b10);
         if (!busy && m_arvalid != 2'b00) e_ar[w] = 1'b1;
         if (busy && !sent) e_sv = 1'b1;
         if (busy && sent) begin
            e_rv[owner] = s_rvalid;
            e_sr        = m_rready[owner];
         end
         chk($sformatf("rand[%0d]", c),
             {m_arready, s_arvalid, s_araddr, s_arprot, m_rvalid, s_rready, m_rdata, m_rresp},
             {e_ar, e_sv, maddr, mprot, e_rv, e_sr, {s_rdata, s_rdata}, {s_rresp, s_rresp}});

         if (!busy && m_arvalid != 2'b00) begin
            busy    = 1;
            sent    = 0;
            owner   = w;
            maddr   = req_addr[w];
            mprot   = req_prot[w];
            pend[w] = 0;
         end else if (busy && !sent && s_arready) begin
            sent = 1;
         end else if (busy && sent && s_rvalid && m_rready[owner]) begin
            busy = 0;
            mp   = RR ? !owner : 1'b0;
         end
         next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
